// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared seven-segment definitions for the score display.
//               Holds the active-low glyph table ({g,f,e,d,c,b,a}), the dash
//               and all-off patterns, and a helper that sizes the BCD scratch
//               for a binary input of a given width.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,     // 0
        7'b1111001,     // 1
        7'b0100100,     // 2
        7'b0110000,     // 3
        7'b0011001,     // 4
        7'b0010010,     // 5
        7'b0000010,     // 6
        7'b1111000,     // 7
        7'b0000000,     // 8
        7'b0010000      // 9
    };

    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Number of BCD nibbles needed for a score_w-bit value:
    // ceil(score_w * log10(2)) + 1. log10(2) is approximated as 0.30103; the
    // product is never an integer, so the integer ceiling is exact in range.
    function automatic int bcd_digits(input int score_w);
        return ((score_w * 30103) + 99999) / 100000 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble converter. One binary bit is shifted
//               in per cycle, so a conversion takes SCORE_W busy cycles.
// Ports       : clk      - clock
//               clr      - synchronous active-high reset (aborts conversion)
//               i_start  - start request, honoured only while idle
//               i_bin    - binary value captured on an accepted start
//               o_busy   - conversion in progress
//               o_done   - one-cycle pulse after the final shift
//               o_bcd    - BCD result, NDIG nibbles, stable while idle
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int SCORE_W = 10,
    parameter int NDIG    = bcd_digits(SCORE_W)
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                i_start,
    input  logic [SCORE_W-1:0]  i_bin,
    output logic                o_busy,
    output logic                o_done,
    output logic [4*NDIG-1:0]   o_bcd
);

    localparam int c_CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SCORE_W - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_CONV = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [SCORE_W-1:0]  r_bin;
    logic [4*NDIG-1:0]   r_scratch;
    logic                r_done;
    logic [4*NDIG-1:0]   w_adj;
    logic [4*NDIG-1:0]   w_shifted;

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (i_start)              w_state_nxt = c_ST_CONV;
            c_ST_CONV: if (r_cnt == c_CNT_LAST)  w_state_nxt = c_ST_IDLE;
            default:                             w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Add-3 correction on every nibble >= 5, then shift in the next binary MSB
    always_comb begin
        w_adj = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (r_scratch[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
            end else begin
                w_adj[4*k +: 4] = r_scratch[4*k +: 4];
            end
        end
        w_shifted = {w_adj[4*NDIG-2:0], r_bin[SCORE_W-1]};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt     <= '0;
            r_bin     <= '0;
            r_scratch <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state == c_ST_IDLE) && i_start) begin
                r_bin     <= i_bin;
                r_scratch <= '0;
                r_cnt     <= '0;
            end else if (r_state == c_ST_CONV) begin
                r_scratch <= w_shifted;
                r_bin     <= r_bin << 1;
                r_cnt     <= r_cnt + c_CNT_W'(1);
                if (r_cnt == c_CNT_LAST) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy = (r_state == c_ST_CONV);
    assign o_done = r_done;
    assign o_bcd  = r_scratch;

endmodule
`default_nettype wire

// File: rtl/score_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : score_display_mux
// Description : Selects one of two binary scores, converts it to BCD with a
//               sequential double-dabble engine and time-multiplexes it onto
//               NUM_DIGITS active-low seven-segment digits, with leading-zero
//               blanking, overflow dashes and whole-display blink.
// Ports       : clk      - clock
//               clr      - synchronous active-high reset
//               score_a  - current score
//               score_b  - highest score
//               sel_b    - 1 selects score_b, sampled with load
//               load     - one-cycle request to convert and display
//               blank_lz - enable leading-zero blanking
//               blink_en - enable whole-display blinking
//               seg      - segments {g,f,e,d,c,b,a}, active-low
//               an       - digit anodes, active-low, bit 0 = least significant
//               dp       - decimal point, always off
//               busy     - conversion in progress
//               done     - one-cycle pulse when the displayed value updates
//               ovf      - value does not fit in NUM_DIGITS digits
// Revision    : 1.0 - initial release
// ============================================================================
module score_display_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCORE_W     = 10,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [SCORE_W-1:0]     score_a,
    input  logic [SCORE_W-1:0]     score_b,
    input  logic                   sel_b,
    input  logic                   load,
    input  logic                   blank_lz,
    input  logic                   blink_en,
    output logic [6:0]             seg,
    output logic [NUM_DIGITS-1:0]  an,
    output logic                   dp,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf
);

    localparam int c_BCD_DIG = bcd_digits(SCORE_W);
    localparam int c_REF_W   = $clog2(REFRESH_DIV);
    localparam int c_BLK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int c_IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(BLINK_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);

    // Converter interface
    logic                     w_start;
    logic [SCORE_W-1:0]       w_sel_score;
    logic                     w_conv_busy;
    logic                     w_conv_done;
    logic [4*c_BCD_DIG-1:0]   w_bcd;
    logic [4*NUM_DIGITS-1:0]  w_bcd_low;
    logic                     w_bcd_ovf;

    // Display state
    logic [4*NUM_DIGITS-1:0]  r_disp;
    logic                     r_ovf;
    logic                     r_done;
    logic [c_REF_W-1:0]       r_refresh;
    logic [c_IDX_W-1:0]       r_idx;
    logic [c_BLK_W-1:0]       r_blk_cnt;
    logic                     r_blk_off;
    logic [NUM_DIGITS-1:0]    r_an;
    logic [6:0]               r_seg;

    // Next-cycle scan values
    logic                     w_ref_wrap;
    logic [c_IDX_W-1:0]       w_idx_nxt;
    logic                     w_blk_off_nxt;
    logic [NUM_DIGITS-1:0]    w_zero_from;
    logic                     w_run_zero;
    logic [3:0]               w_nib;
    logic                     w_sel_zero;
    logic                     w_blank;
    logic [NUM_DIGITS-1:0]    w_an_nxt;
    logic [6:0]               w_seg_nxt;

    // Only an idle converter accepts a request; a load while busy is dropped.
    assign w_start     = load & ~w_conv_busy;
    assign w_sel_score = sel_b ? score_b : score_a;

    bin2bcd_seq #(
        .SCORE_W (SCORE_W),
        .NDIG    (c_BCD_DIG)
    ) u_bin2bcd (
        .clk     (clk),
        .clr     (clr),
        .i_start (w_start),
        .i_bin   (w_sel_score),
        .o_busy  (w_conv_busy),
        .o_done  (w_conv_done),
        .o_bcd   (w_bcd)
    );

    // Split the converter result into the displayed digits and the overflow
    // nibbles; a narrow score on a wide display simply zero-extends.
    generate
        if (c_BCD_DIG > NUM_DIGITS) begin : g_ovf_chk
            assign w_bcd_low = w_bcd[4*NUM_DIGITS-1:0];
            assign w_bcd_ovf = |w_bcd[4*c_BCD_DIG-1:4*NUM_DIGITS];
        end else begin : g_no_ovf
            always_comb begin
                w_bcd_low = '0;
                w_bcd_low[4*c_BCD_DIG-1:0] = w_bcd;
            end
            assign w_bcd_ovf = 1'b0;
        end
    endgenerate

    // Scan and blink next-state. an/seg are registered from these next values
    // so the anode and its segments change on the same edge as the slot.
    always_comb begin
        w_ref_wrap = (r_refresh == c_REF_LAST);
        w_idx_nxt  = r_idx;
        if (w_ref_wrap) begin
            w_idx_nxt = (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
        end

        w_blk_off_nxt = r_blk_off;
        if (!blink_en) begin
            w_blk_off_nxt = 1'b0;
        end else if (r_blk_cnt == c_BLK_LAST) begin
            w_blk_off_nxt = ~r_blk_off;
        end
    end

    // w_zero_from[k]: digit k and every digit above it are zero
    always_comb begin
        w_zero_from = '0;
        w_run_zero  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_run_zero     = w_run_zero & (r_disp[4*k +: 4] == 4'd0);
            w_zero_from[k] = w_run_zero;
        end
    end

    always_comb begin
        w_nib      = 4'd0;
        w_sel_zero = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_idx_nxt == c_IDX_W'(k)) begin
                w_nib      = r_disp[4*k +: 4];
                w_sel_zero = w_zero_from[k];
            end
        end

        // Digit 0 always shows; overflow dashes are never blanked.
        w_blank = blank_lz & ~r_ovf & (w_idx_nxt != '0) & w_sel_zero;

        w_an_nxt = '1;
        if (!w_blk_off_nxt && !w_blank) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (w_idx_nxt == c_IDX_W'(k)) begin
                    w_an_nxt[k] = 1'b0;
                end
            end
        end

        if (r_ovf) begin
            w_seg_nxt = SEG_DASH;
        end else if (w_nib <= 4'd9) begin
            w_seg_nxt = SEG_DIGIT[w_nib];
        end else begin
            w_seg_nxt = SEG_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_disp    <= '0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
            r_refresh <= '0;
            r_idx     <= '0;
            r_blk_cnt <= '0;
            r_blk_off <= 1'b0;
            r_an      <= '1;
            r_seg     <= SEG_OFF;
        end else begin
            // The display register only ever takes a finished conversion.
            r_done <= w_conv_done;
            if (w_conv_done) begin
                r_disp <= w_bcd_low;
                r_ovf  <= w_bcd_ovf;
            end

            r_refresh <= w_ref_wrap ? '0 : r_refresh + c_REF_W'(1);
            r_idx     <= w_idx_nxt;

            if (!blink_en) begin
                r_blk_cnt <= '0;
            end else begin
                r_blk_cnt <= (r_blk_cnt == c_BLK_LAST) ? '0 : r_blk_cnt + c_BLK_W'(1);
            end
            r_blk_off <= w_blk_off_nxt;

            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign seg  = r_seg;
    assign an   = r_an;
    assign dp   = 1'b1;
    assign busy = w_conv_busy;
    assign done = r_done;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_score_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_display_mux
// Description : Directed self-checking bench for score_display_mux. One
//               instance uses a 10-bit score, a second a 14-bit score for the
//               overflow cases; both scan with a 4-cycle slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_display_mux;

    logic        clk = 1'b0;
    logic        clr, sel_b, load10, load14, blank_lz, blink_en;
    logic [13:0] score_a, score_b;

    logic [6:0]  seg10, seg14;
    logic [3:0]  an10, an14;
    logic        dp10, dp14, busy10, busy14, done10, done14, ovf10, ovf14;

    bit          sel_dut = 1'b0;
    logic [6:0]  seg_s;
    logic [3:0]  an_s;
    logic        busy_s, done_s, ovf_s, dp_s;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] DASH = 7'b0111111;

    always #5 clk = ~clk;

    score_display_mux #(
        .NUM_DIGITS(4), .SCORE_W(10), .REFRESH_DIV(4), .BLINK_DIV(8)
    ) dut (
        .clk(clk), .clr(clr), .score_a(score_a[9:0]), .score_b(score_b[9:0]),
        .sel_b(sel_b), .load(load10), .blank_lz(blank_lz), .blink_en(blink_en),
        .seg(seg10), .an(an10), .dp(dp10), .busy(busy10), .done(done10), .ovf(ovf10)
    );

    score_display_mux #(
        .NUM_DIGITS(4), .SCORE_W(14), .REFRESH_DIV(4), .BLINK_DIV(8)
    ) dut14 (
        .clk(clk), .clr(clr), .score_a(score_a), .score_b(score_b),
        .sel_b(sel_b), .load(load14), .blank_lz(blank_lz), .blink_en(blink_en),
        .seg(seg14), .an(an14), .dp(dp14), .busy(busy14), .done(done14), .ovf(ovf14)
    );

    assign seg_s  = sel_dut ? seg14  : seg10;
    assign an_s   = sel_dut ? an14   : an10;
    assign busy_s = sel_dut ? busy14 : busy10;
    assign done_s = sel_dut ? done14 : done10;
    assign ovf_s  = sel_dut ? ovf14  : ovf10;
    assign dp_s   = sel_dut ? dp14   : dp10;

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return DASH;
        endcase
    endfunction

    function automatic logic [27:0] pack4(input int d3, input int d2, input int d1, input int d0);
        return {seg_code(d3), seg_code(d2), seg_code(d1), seg_code(d0)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input bit use14);
        if (use14) load14 = 1'b1; else load10 = 1'b1;
        tick();
        load10 = 1'b0;
        load14 = 1'b0;
    endtask

    // Called #1 after the load edge; done must appear exp_k edges later.
    task automatic wait_done(input int exp_k, input string name);
        int got;
        got = 0;
        for (int k = 1; k <= exp_k + 5; k++) begin
            tick();
            if (done_s === 1'b1 && got == 0) got = k;
        end
        n_checks++;
        if (got != exp_k) begin
            n_fail++;
            $display("FAIL %s done_latency: got edge %0d required %0d", name, got, exp_k);
        end
    endtask

    // Samples 24 cycles (six slots) and checks every lit digit's segments,
    // the one-hot anode, the set of visible digits and, if strict, the scan
    // order and the 4-cycle slot length.
    task automatic check_display(input logic [27:0] exp_seg, input logic [3:0] exp_vis,
                                 input bit strict, input string name);
        logic [3:0] seen;
        int prev_k, run, k;
        bit had_change;
        seen = 4'b0; prev_k = -1; run = 0; had_change = 1'b0;
        tick();
        tick();
        for (int c = 0; c < 24; c++) begin
            tick();
            if (an_s !== 4'hF) begin
                k = -1;
                for (int j = 0; j < 4; j++) if (an_s == ~(4'b0001 << j)) k = j;
                n_checks++;
                if (k < 0) begin
                    n_fail++;
                    $display("FAIL %s an_onehot: an=%b required exactly one low bit", name, an_s);
                end else begin
                    seen[k] = 1'b1;
                    n_checks++;
                    if (seg_s !== exp_seg[7*k +: 7]) begin
                        n_fail++;
                        $display("FAIL %s seg_digit%0d: seg=%b required %b", name, k, seg_s, exp_seg[7*k +: 7]);
                    end
                    if (strict && k != prev_k && prev_k >= 0) begin
                        n_checks++;
                        if (k != (prev_k + 1) % 4) begin
                            n_fail++;
                            $display("FAIL %s scan_order: digit %0d after %0d required %0d", name, k, prev_k, (prev_k + 1) % 4);
                        end
                        if (had_change) begin
                            n_checks++;
                            if (run != 4) begin
                                n_fail++;
                                $display("FAIL %s slot_len: %0d cycles required 4", name, run);
                            end
                        end
                        had_change = 1'b1;
                    end
                    if (k != prev_k) run = 1; else run++;
                    prev_k = k;
                end
            end
        end
        n_checks++;
        if (seen !== exp_vis) begin
            n_fail++;
            $display("FAIL %s visible_digits: %b required %b", name, seen, exp_vis);
        end
    endtask

    task automatic test_reset;
        clr = 1'b1; sel_b = 1'b0; load10 = 1'b0; load14 = 1'b0;
        blank_lz = 1'b0; blink_en = 1'b0; score_a = '0; score_b = '0;
        sel_dut = 1'b0;
        repeat (3) tick();
        n_checks++; if (seg_s !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: %b required 1111111", seg_s); end
        n_checks++; if (an_s !== 4'hF)   begin n_fail++; $display("FAIL reset_an: %b required 1111", an_s); end
        n_checks++; if (an14 !== 4'hF)   begin n_fail++; $display("FAIL reset_an14: %b required 1111", an14); end
        n_checks++; if (dp_s !== 1'b1)   begin n_fail++; $display("FAIL reset_dp: %b required 1", dp_s); end
        n_checks++; if (busy_s !== 1'b0) begin n_fail++; $display("FAIL reset_busy: %b required 0", busy_s); end
        n_checks++; if (done_s !== 1'b0) begin n_fail++; $display("FAIL reset_done: %b required 0", done_s); end
        n_checks++; if (ovf_s !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf: %b required 0", ovf_s); end
        clr = 1'b0;
        tick();
    endtask

    task automatic test_convert;
        logic exp_busy, exp_done;
        sel_dut = 1'b0;
        score_a = 14'd1023; sel_b = 1'b0;
        pulse_load(1'b0);
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) tick();
            exp_busy = (k < 10);
            exp_done = (k == 11);
            n_checks++;
            if (busy_s !== exp_busy) begin
                n_fail++;
                $display("FAIL convert_busy_e%0d: %b required %b", k, busy_s, exp_busy);
            end
            n_checks++;
            if (done_s !== exp_done) begin
                n_fail++;
                $display("FAIL convert_done_e%0d: %b required %b", k, done_s, exp_done);
            end
        end
        n_checks++; if (ovf_s !== 1'b0) begin n_fail++; $display("FAIL convert_ovf: %b required 0", ovf_s); end
        n_checks++; if (dp_s !== 1'b1)  begin n_fail++; $display("FAIL convert_dp: %b required 1", dp_s); end
        check_display(pack4(1, 0, 2, 3), 4'hF, 1'b1, "convert_1023");
    endtask

    task automatic test_blank;
        sel_dut = 1'b0;
        blank_lz = 1'b1;
        score_b = 14'd7; sel_b = 1'b1;
        pulse_load(1'b0);
        wait_done(11, "blank_7");
        check_display(pack4(0, 0, 0, 7), 4'b0001, 1'b0, "blank_7");
        score_a = 14'd105; sel_b = 1'b0;
        pulse_load(1'b0);
        wait_done(11, "blank_105");
        check_display(pack4(0, 1, 0, 5), 4'b0111, 1'b0, "blank_105");
        score_a = 14'd0;
        pulse_load(1'b0);
        wait_done(11, "blank_0");
        check_display(pack4(0, 0, 0, 0), 4'b0001, 1'b0, "blank_0");
        blank_lz = 1'b0;
    endtask

    task automatic test_ovf;
        sel_dut = 1'b1;
        blank_lz = 1'b1;
        score_a = 14'd10000; sel_b = 1'b0;
        pulse_load(1'b1);
        wait_done(15, "ovf_10000");
        n_checks++; if (ovf_s !== 1'b1) begin n_fail++; $display("FAIL ovf_set: %b required 1", ovf_s); end
        check_display({4{DASH}}, 4'hF, 1'b1, "ovf_10000");
        score_a = 14'd9999;
        pulse_load(1'b1);
        wait_done(15, "ovf_9999");
        n_checks++; if (ovf_s !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: %b required 0", ovf_s); end
        check_display(pack4(9, 9, 9, 9), 4'hF, 1'b1, "ovf_9999");
        blank_lz = 1'b0;
        sel_dut = 1'b0;
    endtask

    task automatic test_back_to_back;
        int dcount, dk;
        sel_dut = 1'b0;
        score_a = 14'd512; sel_b = 1'b0;
        pulse_load(1'b0);
        tick();
        tick();
        score_a = 14'd3;
        load10 = 1'b1;
        n_checks++; if (busy_s !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: %b required 1", busy_s); end
        tick();
        load10 = 1'b0;
        score_a = 14'd777;
        dcount = 0; dk = -1;
        for (int k = 4; k <= 30; k++) begin
            tick();
            if (done_s === 1'b1) begin dcount++; dk = k; end
        end
        n_checks++; if (dcount != 1) begin n_fail++; $display("FAIL b2b_done_count: %0d required 1", dcount); end
        n_checks++; if (dk != 11)    begin n_fail++; $display("FAIL b2b_done_edge: %0d required 11", dk); end
        check_display(pack4(0, 5, 1, 2), 4'hF, 1'b0, "b2b_512");
    endtask

    task automatic test_clr_mid;
        bit saw_done;
        sel_dut = 1'b0;
        score_a = 14'd999; sel_b = 1'b0;
        pulse_load(1'b0);
        repeat (4) tick();
        clr = 1'b1;
        tick();
        n_checks++; if (busy_s !== 1'b0) begin n_fail++; $display("FAIL clr_busy: %b required 0", busy_s); end
        n_checks++; if (done_s !== 1'b0) begin n_fail++; $display("FAIL clr_done: %b required 0", done_s); end
        n_checks++; if (an_s !== 4'hF)   begin n_fail++; $display("FAIL clr_an: %b required 1111", an_s); end
        n_checks++; if (seg_s !== 7'h7F) begin n_fail++; $display("FAIL clr_seg: %b required 1111111", seg_s); end
        tick();
        n_checks++; if (an_s !== 4'hF)   begin n_fail++; $display("FAIL clr_an_hold: %b required 1111", an_s); end
        clr = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done_s === 1'b1) saw_done = 1'b1;
        end
        n_checks++; if (saw_done) begin n_fail++; $display("FAIL clr_no_done: saw done required none"); end
        check_display(pack4(0, 0, 0, 0), 4'hF, 1'b0, "clr_display");
    endtask

    task automatic test_blink;
        bit exp_off;
        sel_dut = 1'b0;
        blank_lz = 1'b0;
        blink_en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_off = (k >= 8 && k <= 15);
            n_checks++;
            if ((an_s === 4'hF) != exp_off) begin
                n_fail++;
                $display("FAIL blink_cycle%0d: an=%b required off=%b", k, an_s, exp_off);
            end
        end
        blink_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks++;
            if (an_s === 4'hF) begin
                n_fail++;
                $display("FAIL blink_disabled%0d: an=%b required a lit digit", k, an_s);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_convert();
        test_blank();
        test_ovf();
        test_back_to_back();
        test_clr_mid();
        test_blink();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/score_display_mux.md
Name: score_display_mux

Overview:
- Parametrised successor to the fixed 4-digit seven-segment driver.
- Accepts two binary scores, current and highest, and selects one of them.
- Converts the selected score to BCD with a sequential double-dabble engine, then time-multiplexes NUM_DIGITS active-low digits.
- Adds leading-zero blanking, overflow indication and whole-display blink.
- Sits beside the VGA controller and is fed by the game block's current_score and highest_score.

Parameters:
- NUM_DIGITS, 4, number of displayed digits and width of an; range 1..8.
- SCORE_W, 10, width of each binary score input.
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); minimum 2.
- BLINK_DIV, 25000000, clk cycles per blink half-period (2 Hz blink at 100 MHz).

Ports:
- clk  in  1  master clock, 100 MHz
- clr  in  1  synchronous active-high reset
- score_a  in  SCORE_W  binary score A (current)
- score_b  in  SCORE_W  binary score B (highest)
- sel_b  in  1  0 = convert score_a, 1 = convert score_b; sampled with load
- load  in  1  one-cycle request to convert and display the selected score
- blank_lz  in  1  enable leading-zero blanking
- blink_en  in  1  enable whole-display blinking
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- an  out  NUM_DIGITS  digit anodes, active-low; bit 0 is the least significant digit
- dp  out  1  decimal point, constant 1 (off)
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse when the displayed value updates
- ovf  out  1  displayed value exceeds 10^NUM_DIGITS-1

Behaviour:
- Clock and reset: one clock, clk. Reset is clr, synchronous and active-high. All outputs are registered.
- Reset values (clr=1):
  - seg=7'b1111111, an all 1s, dp=1, busy=0, done=0, ovf=0.
  - Display BCD register = 0; refresh counter, digit index and blink counter = 0; blink phase = on.
- Load acceptance:
  - Accepted only on a cycle where load=1, busy=0 and clr=0.
  - On acceptance, capture sel_b ? score_b : score_a into the shift register and clear the BCD scratch.
  - A load while busy=1 is ignored: no queueing, no effect on the running conversion.
- Conversion:
  - busy=1 for exactly SCORE_W cycles, starting the cycle after acceptance.
  - Each cycle: add 3 to every scratch BCD nibble that is >=5, then shift left by one, taking the MSB of the binary value.
  - On the cycle busy falls, scratch is copied to the display register, ovf is computed, and done=1 for that single cycle.
  - Latency from the load edge to the display update is SCORE_W+1 cycles.
  - The display register never shows a partial conversion.
- Width rules:
  - Scratch holds ceil(SCORE_W*log10(2))+1 nibbles.
  - ovf=1 if any nibble at index >= NUM_DIGITS is nonzero.
  - When ovf=1, every digit shows dash (seg=7'b0111111) and blanking is ignored.
- Scanning:
  - The refresh counter wraps at REFRESH_DIV-1. On wrap, the digit index advances, wrapping from NUM_DIGITS-1 to 0.
  - Exactly one an bit is low per slot. seg is updated on the same edge as an, so there is no ghosting cycle.
  - Scanning runs continuously, independent of busy.
- Leading-zero blanking:
  - When blank_lz=1, digit k is blanked (an bit held high) if it and all higher digits are 0.
  - Digit 0 is never blanked, so a value of 0 shows "0".
- Blink:
  - When blink_en=1, the phase toggles every BLINK_DIV cycles. In the off phase all an bits are 1.
  - When blink_en=0, the phase counter is held at 0 and the phase is on.
- Seven-segment encoding (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Reset mid-conversion: the conversion is aborted, busy=0, display=0, no done pulse.
- Simultaneous load and clr: clr wins.
- score_a/score_b changing during busy: no effect on the running conversion.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_DIGIT[0:9] encodings, SEG_DASH, SEG_OFF;
  - function bcd_digits(SCORE_W) for scratch sizing.
- Sub-module bin2bcd_seq (params SCORE_W, NDIG) contains the double-dabble engine with start/busy/done.
- The top level holds the refresh, blink, blanking and anode logic.

Test Plan:
- Reset, then load score_a=1023, sel_b=0 (REFRESH_DIV=4) -> busy high 10 cycles; done at edge 11; scan order an=1110/1101/1011/0111 with seg 0110000/0100100/1000000/1111001 (digits 3,2,0,1).
- blank_lz=1, load score_b=7, sel_b=1 -> digit 0 seg=1111000, an[3:1] stay 1 every slot; then load 0 -> digit 0 seg=1000000.
- SCORE_W=14, NUM_DIGITS=4, load 10000 -> ovf=1, all four slots seg=0111111; then load 9999 -> ovf=0, all slots 0010000.
- Load 512, second load of 3 three cycles later -> second ignored; done once; display 512.
- clr asserted 5 cycles after load -> busy=0 next cycle, no done, display 0, an all 1 while clr=1.
- blink_en=1, BLINK_DIV=8 -> an all 1s for cycles 8-15, scanning resumes at 16; blink_en=0 -> no off phase.
